// File: rtl/qei_speed_pkg.sv
// Shared configuration for the QEI speed estimator: system clock, counter width,
// sampling rate, averaging window and output width used by the top-level instance.
package qei_speed_pkg;

  localparam int CLK_FREQ          = 48000000;
  localparam int QEI_NBITS         = 16;
  localparam int SPEED_SAMPLE_FREQ = 1000;
  localparam int SPEED_AVG_LOG2    = 2;
  localparam int SPEED_BITS        = 16;

endpackage

// File: rtl/qei_speed_window.sv
// Moving-average window: ring of the last 2^avgLog2 deltas with a running sum.
// sum/full present the window state including this cycle's push, so the caller can register them directly.
module qei_speed_window #(
  parameter int nBits   = 16,
  parameter int avgLog2 = 2
) (
  input  logic                             clk,
  input  logic                             clr,
  input  logic                             push,
  input  logic signed [nBits-1:0]          delta,
  output logic signed [nBits+avgLog2-1:0]  sum,
  output logic                             full
);

  localparam int DEPTH = 1 << avgLog2;
  localparam int PW    = (avgLog2 > 0) ? avgLog2 : 1;
  localparam int FW    = avgLog2 + 1;
  localparam int SW    = nBits + avgLog2;
  localparam logic [FW-1:0] FULLCNT = FW'(DEPTH);

  logic signed [nBits-1:0] ring [DEPTH];
  logic [PW-1:0]           wrPtr;
  logic [FW-1:0]           fill;
  logic [FW-1:0]           fillNext;
  logic signed [SW-1:0]    sumQ;
  logic signed [SW-1:0]    sumNext;
  logic signed [SW-1:0]    deltaExt;
  logic signed [SW-1:0]    oldExt;

  always_comb begin
    deltaExt = delta;
    oldExt   = ring[wrPtr];
    sumNext  = sumQ;
    fillNext = fill;
    if (push) begin
      // The entry being overwritten leaves the window as the new delta enters it.
      sumNext = sumQ + deltaExt - oldExt;
      if (fill != FULLCNT) fillNext = fill + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sumQ  <= '0;
      fill  <= '0;
      wrPtr <= '0;
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
    end else if (push) begin
      ring[wrPtr] <= delta;
      wrPtr       <= (DEPTH == 1) ? '0 : wrPtr + PW'(1);
      sumQ        <= sumNext;
      fill        <= fillNext;
    end
  end

  assign sum  = sumNext;
  assign full = (fillNext == FULLCNT);

endmodule

// File: rtl/qei_speed.sv
// Speed estimator: samples the wrapping QEI position at a fixed rate, averages the
// signed per-sample delta over a window and emits a saturated speed with a valid strobe.
module qei_speed
  import qei_speed_pkg::*;
#(
  parameter int clkFreq    = CLK_FREQ,
  parameter int sampleFreq = SPEED_SAMPLE_FREQ,
  parameter int nBits      = QEI_NBITS,
  parameter int avgLog2    = SPEED_AVG_LOG2,
  parameter int sBits      = SPEED_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [nBits-1:0]         pos,
  output logic signed [sBits-1:0]  speed,
  output logic                     valid,
  output logic                     ovf
);

  localparam int DIV = clkFreq / sampleFreq;
  localparam int CW  = $clog2(DIV);
  localparam int SW  = nBits + avgLog2;
  localparam logic signed [SW-1:0] SMAX = SW'((2 ** (sBits - 1)) - 1);
  localparam logic signed [SW-1:0] SMIN = SW'(-(2 ** (sBits - 1)));

  logic [CW-1:0]           tickCnt;
  logic                    tick;
  logic                    primed;
  logic                    push;
  logic                    winClr;
  logic                    winFull;
  logic [nBits-1:0]        posPrev;
  logic signed [nBits-1:0] delta;
  logic signed [SW-1:0]    winSum;
  logic signed [SW-1:0]    avg;
  logic signed [sBits-1:0] satVal;
  logic                    clip;

  assign tick   = en && (tickCnt == CW'(DIV - 1));
  assign winClr = rst || clr;
  // The priming tick only captures a reference position; it carries no delta.
  assign push   = tick && primed && !winClr;
  // Modular subtraction makes a counter wrap look like a small step.
  assign delta  = $signed(pos - posPrev);
  assign avg    = winSum >>> avgLog2;

  always_comb begin
    clip   = 1'b0;
    satVal = avg[sBits-1:0];
    if (avg > SMAX) begin
      clip   = 1'b1;
      satVal = SMAX[sBits-1:0];
    end else if (avg < SMIN) begin
      clip   = 1'b1;
      satVal = SMIN[sBits-1:0];
    end
  end

  qei_speed_window #(
    .nBits   (nBits),
    .avgLog2 (avgLog2)
  ) u_window (
    .clk   (clk),
    .clr   (winClr),
    .push  (push),
    .delta (delta),
    .sum   (winSum),
    .full  (winFull)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tickCnt <= '0;
      primed  <= 1'b0;
      posPrev <= '0;
      speed   <= '0;
      valid   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (en) tickCnt <= tick ? '0 : tickCnt + CW'(1);
      if (tick) begin
        posPrev <= pos;
        primed  <= 1'b1;
      end
      if (push && winFull) begin
        speed <= satVal;
        valid <= 1'b1;
        if (clip) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qei_speed.sv
// Bench for qei_speed: two instances (16-bit and 8-bit speed) share stimulus and are
// compared every cycle against a sample-history model, plus directed literal checks.
module tb_qei_speed;

  localparam int DIV = 8;
  localparam int WIN = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               clr;
  logic [15:0]        pos;
  logic signed [15:0] speed16;
  logic               valid16;
  logic               ovf16;
  logic signed [7:0]  speed8;
  logic               valid8;
  logic               ovf8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  qei_speed #(
    .clkFreq (8), .sampleFreq (1), .nBits (16), .avgLog2 (2), .sBits (16)
  ) dut16 (
    .clk (clk), .rst (rst), .en (en), .clr (clr), .pos (pos),
    .speed (speed16), .valid (valid16), .ovf (ovf16)
  );

  qei_speed #(
    .clkFreq (8), .sampleFreq (1), .nBits (16), .avgLog2 (2), .sBits (8)
  ) dut8 (
    .clk (clk), .rst (rst), .en (en), .clr (clr), .pos (pos),
    .speed (speed8), .valid (valid8), .ovf (ovf8)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wrapDelta(input int diff);
    int d;
    d = ((diff % 65536) + 65536) % 65536;
    if (d >= 32768) d -= 65536;
    return d;
  endfunction

  function automatic int floorDiv(input int t, input int w);
    if (t >= 0) return t / w;
    return -((-t + w - 1) / w);
  endfunction

  function automatic int clampTo(input int v, input int bits);
    int hi, lo;
    hi = (1 << (bits - 1)) - 1;
    lo = -(1 << (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference model: positions seen at sample instants; once WIN+1 are held the
  // speed is the floored mean of the last WIN wrapped differences.
  int  samples[$];
  int  mRun = 0;
  int  mValid = 0;
  int  mSpeed16 = 0;
  int  mSpeed8 = 0;
  int  mOvf16 = 0;
  int  mOvf8 = 0;
  bit  started = 1'b0;

  always @(posedge clk) begin
    int sumD;
    int avgV;
    started = 1'b1;
    mValid  = 0;
    if (rst || clr) begin
      mRun = 0;
      samples.delete();
      mSpeed16 = 0;
      mSpeed8  = 0;
      mOvf16   = 0;
      mOvf8    = 0;
    end else if (en) begin
      if (mRun % DIV == DIV - 1) begin
        samples.push_back(int'(pos));
        if (samples.size() > WIN + 1) void'(samples.pop_front());
        if (samples.size() == WIN + 1) begin
          sumD = 0;
          for (int k = 1; k <= WIN; k++) sumD += wrapDelta(samples[k] - samples[k-1]);
          avgV     = floorDiv(sumD, WIN);
          mValid   = 1;
          mSpeed16 = clampTo(avgV, 16);
          mSpeed8  = clampTo(avgV, 8);
          if (mSpeed16 != avgV) mOvf16 = 1;
          if (mSpeed8 != avgV) mOvf8 = 1;
        end
      end
      mRun++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("valid16", int'(valid16), mValid);
      chk("speed16", int'(speed16), mSpeed16);
      chk("ovf16",   int'(ovf16),   mOvf16);
      chk("valid8",  int'(valid8),  mValid);
      chk("speed8",  int'(speed8),  mSpeed8);
      chk("ovf8",    int'(ovf8),    mOvf8);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic period(input int step);
    cyc(DIV);
    pos = pos + 16'(step);
  endtask

  task automatic pulseClr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
  endtask

  task automatic waitValid(input string name, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!valid16 && n < 200);
    if (!valid16) chk({name, "_timeout"}, n, -1);
  endtask

  initial begin
    int n;
    int nv;
    rst = 1'b1;
    en  = 1'b1;
    clr = 1'b0;
    pos = 16'd100;
    cyc(3);
    chk("rst_speed", int'(speed16), 0);
    chk("rst_valid", int'(valid16), 0);
    chk("rst_ovf",   int'(ovf16),   0);
    rst = 1'b0;
    waitValid("first", n);
    chk("first_valid_latency", n, 40);
    chk("first_speed", int'(speed16), 0);

    // Ramp +10 per period
    for (int i = 0; i < 6; i++) period(10);
    waitValid("ramp", n);
    chk("ramp_speed", int'(speed16), 10);
    chk("ramp_model", mSpeed16, 10);
    waitValid("ramp_gap", n);
    chk("ramp_valid_period", n, 8);

    // Wrap forward across FFFA->0004 and back
    pos = 16'hFFD2;
    pulseClr();
    for (int i = 0; i < 9; i++) period(10);
    waitValid("wrap_up", n);
    chk("wrap_up_speed", int'(speed16), 10);
    for (int i = 0; i < 10; i++) period(-10);
    waitValid("wrap_down", n);
    chk("wrap_down_speed", int'(speed16), -10);
    chk("wrap_ovf", int'(ovf16), 0);

    // Floor rounding
    pulseClr();
    period(1); period(2); period(3); period(4);
    waitValid("round_pos", n);
    chk("round_pos_speed", int'(speed16), 2);
    chk("round_pos_model", mSpeed16, 2);
    pulseClr();
    period(-1); period(-2); period(-3); period(-4);
    waitValid("round_neg", n);
    chk("round_neg_speed", int'(speed16), -3);
    chk("round_neg_model", mSpeed16, -3);

    // Saturation on the 8-bit instance
    pulseClr();
    for (int i = 0; i < 8; i++) period(200);
    waitValid("sat", n);
    chk("sat_speed8", int'(speed8), 127);
    chk("sat_ovf8", int'(ovf8), 1);
    chk("sat_speed16", int'(speed16), 200);
    chk("sat_ovf16", int'(ovf16), 0);
    for (int i = 0; i < 8; i++) period(5);
    waitValid("sat_low", n);
    chk("sat_low_speed8", int'(speed8), 5);
    chk("sat_low_ovf8", int'(ovf8), 1);
    pulseClr();
    chk("sat_clr_ovf8", int'(ovf8), 0);

    // clr coinciding with a tick
    n = 0;
    while (mRun % DIV != DIV - 1 && n < 16) begin
      cyc(1);
      n++;
    end
    chk("clr_tick_phase", mRun % DIV, DIV - 1);
    pulseClr();
    waitValid("clr_tick", n);
    chk("clr_tick_latency", n, 40);

    // Pause
    for (int i = 0; i < 6; i++) period(10);
    waitValid("pre_pause", n);
    chk("pre_pause_speed", int'(speed16), 10);
    en = 1'b0;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      pos = pos + 16'd3;
      cyc(1);
      if (valid16) nv++;
    end
    chk("pause_valids", nv, 0);
    chk("pause_speed_held", int'(speed16), 10);
    en = 1'b1;
    cyc(40);

    // rst and clr together
    rst = 1'b1;
    clr = 1'b1;
    cyc(1);
    chk("rstclr_speed16", int'(speed16), 0);
    chk("rstclr_valid16", int'(valid16), 0);
    chk("rstclr_ovf16", int'(ovf16), 0);
    chk("rstclr_speed8", int'(speed8), 0);
    chk("rstclr_ovf8", int'(ovf8), 0);
    rst = 1'b0;
    clr = 1'b0;

    // Random phase
    repeat (800) begin
      if ($urandom_range(0, 9) == 0) pos = 16'($urandom);
      else pos = pos + 16'($urandom_range(0, 80)) - 16'd40;
      en  = ($urandom_range(0, 19) != 0);
      clr = ($urandom_range(0, 149) == 0);
      cyc(1);
    end
    clr = 1'b0;
    en  = 1'b1;
    cyc(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
